bram_resp_mem: RTL and testbench
================================

# bram_resp_mem

Synthesizable responder for the 32-bit BRAM-style port driven by the matrix PE controller. It is the memory side of that port. It serves the controller's byte-addressed reads and byte-lane writes with a fixed read latency. A side load port lets the host preload words, and a dump engine streams a result window out over a valid/ready interface when the controller raises `done`. It replaces the simulation-only memory model at integration and gives the bench a cycle-exact, checkable target.

## Interface
- `BRAM_ADDR_WIDTH`, 15: byte-address width; memory depth is 2^(BRAM_ADDR_WIDTH-2) words.
- `RD_LATENCY`, 1: read latency in cycles, legal values 1 or 2.
- `DUMP_BASE`, 0: first word index streamed by the dump engine.
- `DUMP_WORDS`, 64: number of words streamed per dump, 1..depth.
- `aclk` in 1: single clock; the controller's BRAM_CLK is aclk at integration.
- `aresetn` in 1: asynchronous, active-low reset.
- `BRAM_ADDR` in BRAM_ADDR_WIDTH: byte address; word index = BRAM_ADDR[BRAM_ADDR_WIDTH-1:2]; bits [1:0] are ignored.
- `BRAM_WRDATA` in 32: write data.
- `BRAM_WE` in 4: byte-lane write enables; bit i writes byte i.
- `BRAM_EN` in 1: port enable; no read and no write when 0.
- `BRAM_RST` in 1: synchronous clear of the read output register(s).
- `BRAM_RDDATA` out 32: read data.
- `ld_valid` in 1, `ld_ready` out 1, `ld_addr` in BRAM_ADDR_WIDTH-2, `ld_data` in 32: host word-load handshake.
- `done` in 1: controller completion flag, treated as a level.
- `dump_valid` out 1, `dump_ready` in 1, `dump_data` out 32, `dump_addr` out BRAM_ADDR_WIDTH-2, `dump_last` out 1: result stream.
- `busy` out 1: dump in progress.
- `conflict` out 1: sticky flag, set when the port is accessed during a dump.

## Operation
- **Port read:** when BRAM_EN=1, the addressed word appears on BRAM_RDDATA RD_LATENCY cycles later.
  - With RD_LATENCY=2, an extra output register is added.
  - When BRAM_EN=0, the output registers hold their value.
- **Port write:** when BRAM_EN=1, every byte whose BRAM_WE bit is 1 is written at the clock edge.
  - A read and a write to the same address in the same cycle return the old data (read-first).
- **BRAM_RST:** when high at an edge, clears all read output registers to 0. It has priority over a load into those registers. Memory contents are unaffected.
- **Load port:** `ld_ready` = !busy && !(BRAM_EN && |BRAM_WE), combinational.
  - A transfer happens when ld_valid && ld_ready; all 4 bytes of ld_data are written at word ld_addr.
  - A port write in the same cycle wins, so the load stalls.
- **Dump FSM states:** IDLE, RD, WAIT, OUT.
  - IDLE -> RD on a rising edge of `done`; idx = DUMP_BASE, busy=1.
  - RD: issue an internal read of word idx. Go to WAIT if RD_LATENCY=2; otherwise go directly to OUT once the data is registered.
  - WAIT: one cycle, then -> OUT.
  - OUT: dump_valid=1; dump_data, dump_addr=idx and dump_last=(idx==DUMP_BASE+DUMP_WORDS-1) are held stable until dump_ready.
  - On acceptance, if last -> IDLE (busy=0), else idx+1 -> RD.
- **During busy (lockout):**
  - Port writes are dropped.
  - BRAM_RDDATA is driven 0.
  - Any BRAM_EN=1 cycle sets `conflict`. It stays set until reset.
- **`done` edge handling:**
  - Edge detect uses a registered copy `done_q`, which resets to 1. A `done` already high at reset release does not start a dump.
  - A `done` rising edge while busy is ignored.
  - A fresh rising edge after the dump returns to IDLE starts a new dump.
- **Address arithmetic:** idx is BRAM_ADDR_WIDTH-2 bits wide. DUMP_BASE+DUMP_WORDS must not exceed the depth. There is no wrap-around, and overflow is not checked in RTL.

## Timing
- **Reset values:** BRAM_RDDATA=0, dump_valid=0, dump_data=0, dump_addr=0, dump_last=0, busy=0, conflict=0, FSM=IDLE. ld_ready follows its equation (1 if the port is idle). Memory contents are not reset.
- **Reset mid-dump:** FSM returns to IDLE immediately (asynchronous). The partial dump is abandoned and memory is unchanged.
- **Read latency:** address at edge N -> data valid after edge N+RD_LATENCY.
- **Dump start:** `done` rises, is sampled at edge N -> busy=1 after edge N. First dump_valid appears after edge N+1+RD_LATENCY.
- **Dump throughput:** one word per RD_LATENCY+2 cycles when dump_ready is held at 1. Back-pressure extends OUT indefinitely.
- **Dump end:** dump_last and dump_valid are high on the same cycle. busy falls at the edge that accepts the last word.

## Test plan
- **Preload and read (RD_LATENCY=1):** load word 5=0xDEADBEEF via ld port, then port read BRAM_ADDR=0x14 with EN=1 -> BRAM_RDDATA=0xDEADBEEF exactly one cycle later. Repeat with RD_LATENCY=2 -> two cycles later.
- **Byte-lane write:** word 3=0x11223344, port write 0xAABBCCDD with WE=4'b0101 at addr 0xC -> subsequent read returns 0x11BB33DD. A same-cycle read of addr 0xC during that write returns 0x11223344.
- **Load stall:** ld_valid held with port write active for 3 cycles -> ld_ready=0 for those 3 cycles. The load completes on the first idle cycle and the port-written data is preserved at its own address.
- **Dump with back-pressure:** preload words 0..63 with value 0x100+i, pulse done. dump_ready toggles 1/0 every cycle -> 64 beats in order, dump_data=0x100+dump_addr, data stable while stalled, dump_last only on addr 63, busy falls after the last acceptance.
- **Lockout and conflict:** port write addr 0x0 data 0xFFFFFFFF during a dump -> word 0 unchanged, BRAM_RDDATA=0, conflict=1 and still 1 after the dump ends.
- **Reset and done-edge cases:**
  - Assert aresetn=0 at beat 10 of a dump -> all outputs return to reset values, and no dump runs after release even though done is held high.
  - Drop done, raise it again -> a full 64-beat dump runs from word DUMP_BASE.

Source files
------------

// File: rtl/bram_resp_mem_if.sv
// Bus bundle for the BRAM-style responder: controller port, host load port,
// completion flag and the dump result stream, plus status outputs.
interface bram_resp_mem_if #(
  parameter int BRAM_ADDR_WIDTH = 15
);
  logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR;
  logic [31:0]                BRAM_WRDATA;
  logic [3:0]                 BRAM_WE;
  logic                       BRAM_EN;
  logic                       BRAM_RST;
  logic [31:0]                BRAM_RDDATA;

  logic                       ld_valid;
  logic                       ld_ready;
  logic [BRAM_ADDR_WIDTH-3:0] ld_addr;
  logic [31:0]                ld_data;

  logic                       done;

  logic                       dump_valid;
  logic                       dump_ready;
  logic [31:0]                dump_data;
  logic [BRAM_ADDR_WIDTH-3:0] dump_addr;
  logic                       dump_last;

  logic                       busy;
  logic                       conflict;

  // Memory side of the bus
  modport slave (
    input  BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_EN, BRAM_RST,
    output BRAM_RDDATA,
    input  ld_valid, ld_addr, ld_data,
    output ld_ready,
    input  done,
    output dump_valid, dump_data, dump_addr, dump_last,
    input  dump_ready,
    output busy, conflict
  );

  // Controller / host side of the bus
  modport master (
    output BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_EN, BRAM_RST,
    input  BRAM_RDDATA,
    output ld_valid, ld_addr, ld_data,
    input  ld_ready,
    output done,
    input  dump_valid, dump_data, dump_addr, dump_last,
    output dump_ready,
    input  busy, conflict
  );
endinterface

// File: rtl/bram_resp_mem.sv
// Memory-side responder for the matrix PE controller's 32-bit BRAM port.
// Serves byte-lane writes and fixed-latency reads, accepts host word loads,
// and streams a result window out when the controller raises done.
module bram_resp_mem #(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int RD_LATENCY      = 1,
  parameter int DUMP_BASE       = 0,
  parameter int DUMP_WORDS      = 64
) (
  input logic            aclk,
  input logic            aresetn,
  bram_resp_mem_if.slave bus
);
  localparam int AW    = BRAM_ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] BASE_IDX = AW'(DUMP_BASE);
  localparam logic [AW-1:0] LAST_IDX = AW'(DUMP_BASE + DUMP_WORDS - 1);
  localparam bit TWO_STAGE = (RD_LATENCY == 2);

  typedef enum logic [1:0] {IDLE, RD, WAIT, OUT} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state, state_next;
  logic [AW-1:0] idx, idx_next;
  logic          rd_phase, rd_phase_next;
  logic          dump_cap, dump_shift;
  logic [31:0]   dump_d1, dump_d2;
  logic [31:0]   rd_q1, rd_q2;
  logic          en_q;
  logic          done_q;
  logic          done_rise;
  logic          busy;
  logic          conflict_q;
  logic [AW-1:0] port_word;
  logic          port_access;
  logic          port_wr;
  logic          ld_fire;
  logic          unused_addr_bits;

  assign port_word        = bus.BRAM_ADDR[BRAM_ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^bus.BRAM_ADDR[1:0];
  assign busy             = (state != IDLE);
  assign port_access      = bus.BRAM_EN && !busy;
  assign port_wr          = port_access && (|bus.BRAM_WE);
  assign bus.ld_ready     = !busy && !(bus.BRAM_EN && (|bus.BRAM_WE));
  assign ld_fire          = bus.ld_valid && bus.ld_ready;
  assign done_rise        = bus.done && !done_q;

  // Storage writes: port byte lanes win, a host load only lands on a port-idle cycle
  always_ff @(posedge aclk) begin
    if (port_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.BRAM_WE[b]) begin
          mem[port_word][8*b +: 8] <= bus.BRAM_WRDATA[8*b +: 8];
        end
      end
    end else if (ld_fire) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  // Port read pipeline: read-first capture, optional second register, BRAM_RST clears both
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_q1 <= '0;
      rd_q2 <= '0;
      en_q  <= 1'b0;
    end else if (bus.BRAM_RST) begin
      rd_q1 <= '0;
      rd_q2 <= '0;
      en_q  <= 1'b0;
    end else begin
      if (port_access) begin
        rd_q1 <= mem[port_word];
      end
      if (en_q) begin
        rd_q2 <= rd_q1;
      end
      en_q <= port_access;
    end
  end

  // Dump engine state, word index and the done edge detector
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      idx      <= '0;
      rd_phase <= 1'b0;
      done_q   <= 1'b1;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      rd_phase <= rd_phase_next;
      done_q   <= bus.done;
    end
  end

  // Dump data capture for the internal read, with the extra stage when latency is 2
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dump_d1 <= '0;
      dump_d2 <= '0;
    end else begin
      if (dump_cap) begin
        dump_d1 <= mem[idx];
      end
      if (dump_shift) begin
        dump_d2 <= dump_d1;
      end
    end
  end

  // Sticky flag for any controller access attempted while a dump owns the memory
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      conflict_q <= 1'b0;
    end else if (busy && bus.BRAM_EN) begin
      conflict_q <= 1'b1;
    end
  end

  // Dump sequencing: address issue, data register, optional wait, then hold until accepted
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    rd_phase_next = rd_phase;
    dump_cap      = 1'b0;
    dump_shift    = 1'b0;
    case (state)
      IDLE: begin
        if (done_rise) begin
          state_next    = RD;
          idx_next      = BASE_IDX;
          rd_phase_next = 1'b0;
        end
      end
      RD: begin
        if (!rd_phase) begin
          rd_phase_next = 1'b1;
        end else begin
          rd_phase_next = 1'b0;
          dump_cap      = 1'b1;
          state_next    = TWO_STAGE ? WAIT : OUT;
        end
      end
      WAIT: begin
        dump_shift = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        if (bus.dump_ready) begin
          if (idx == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            idx_next   = idx + AW'(1);
            state_next = RD;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.BRAM_RDDATA = busy ? 32'h0 : (TWO_STAGE ? rd_q2 : rd_q1);
  assign bus.dump_valid  = (state == OUT);
  assign bus.dump_data   = TWO_STAGE ? dump_d2 : dump_d1;
  assign bus.dump_addr   = idx;
  assign bus.dump_last   = (state == OUT) && (idx == LAST_IDX);
  assign bus.busy        = busy;
  assign bus.conflict    = conflict_q;
endmodule

// File: tb/tb_bram_resp_mem.sv
// Directed bench for bram_resp_mem: one instance at read latency 1 with a
// 64-word dump from word 0, one at latency 2 with a 4-word dump from word 2.
module tb_bram_resp_mem;
  localparam int AW  = 15;
  localparam int WAW = AW - 2;

  typedef struct packed {
    logic [WAW-1:0] addr;
    logic [31:0]    data;
    logic           last;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] rd_q[$];
  beat_t       beat_q[$];
  logic [31:0] model_mem [int];

  // Free-running 100 MHz clock
  always #5 aclk = ~aclk;

  bram_resp_mem_if #(.BRAM_ADDR_WIDTH(AW)) bus1 ();
  bram_resp_mem_if #(.BRAM_ADDR_WIDTH(AW)) bus2 ();

  bram_resp_mem #(
    .BRAM_ADDR_WIDTH(AW), .RD_LATENCY(1), .DUMP_BASE(0), .DUMP_WORDS(64)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus1)
  );

  bram_resp_mem #(
    .BRAM_ADDR_WIDTH(AW), .RD_LATENCY(2), .DUMP_BASE(2), .DUMP_WORDS(4)
  ) dut2 (
    .aclk(aclk), .aresetn(aresetn), .bus(bus2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic loadWord(input int w, input logic [31:0] d);
    bus1.ld_valid = 1'b1;
    bus1.ld_addr  = WAW'(w);
    bus1.ld_data  = d;
    tick();
    bus1.ld_valid = 1'b0;
    model_mem[w]  = d;
  endtask

  // One port access on the latency-1 instance; expected read is the pre-write word
  task automatic applyStimulus(input logic [3:0] we, input int word, input logic [31:0] wdata, input string tag);
    logic [31:0] cur;
    cur = model_mem[word];
    rd_q.push_back(cur);
    for (int b = 0; b < 4; b++) begin
      if (we[b]) cur[8*b +: 8] = wdata[8*b +: 8];
    end
    model_mem[word]  = cur;
    bus1.BRAM_EN     = 1'b1;
    bus1.BRAM_WE     = we;
    bus1.BRAM_ADDR   = {WAW'(word), 2'b00};
    bus1.BRAM_WRDATA = wdata;
    tick();
    bus1.BRAM_EN     = 1'b0;
    bus1.BRAM_WE     = 4'h0;
    checkOutput(tag, bus1.BRAM_RDDATA, rd_q.pop_front());
  endtask

  task automatic pushDump(input int base, input int n);
    for (int i = base; i < base + n; i++) begin
      beat_q.push_back('{addr: WAW'(i), data: model_mem[i], last: (i == base + n - 1)});
    end
  endtask

  task automatic checkResetState(input string p);
    checkOutput({p, "_rddata"}, bus1.BRAM_RDDATA, 32'h0);
    checkOutput({p, "_valid"}, 32'(bus1.dump_valid), 32'h0);
    checkOutput({p, "_data"}, bus1.dump_data, 32'h0);
    checkOutput({p, "_addr"}, 32'(bus1.dump_addr), 32'h0);
    checkOutput({p, "_last"}, 32'(bus1.dump_last), 32'h0);
    checkOutput({p, "_busy"}, 32'(bus1.busy), 32'h0);
    checkOutput({p, "_conflict"}, 32'(bus1.conflict), 32'h0);
    checkOutput({p, "_ld_ready"}, 32'(bus1.ld_ready), 32'h1);
  endtask

  // Drive dump_ready and score beats on the latency-1 instance
  task automatic runDump(input int abort_after, input bit toggle, input int lockout_iter);
    int          beats;
    int          iter;
    bit          stalled;
    logic [31:0] held_data;
    logic [31:0] held_addr;
    beat_t       exp;
    beats   = 0;
    iter    = 0;
    stalled = 1'b0;
    while (beats < 64) begin
      if (iter >= 2000) begin
        checkOutput("dump_timeout_beats", 32'(beats), 32'd64);
        break;
      end
      bus1.dump_ready = toggle ? (iter % 2 == 1) : 1'b1;
      if (iter == lockout_iter) begin
        bus1.BRAM_EN     = 1'b1;
        bus1.BRAM_WE     = 4'hF;
        bus1.BRAM_ADDR   = '0;
        bus1.BRAM_WRDATA = 32'hFFFF_FFFF;
      end else if (iter == lockout_iter + 1) begin
        bus1.BRAM_EN = 1'b0;
        bus1.BRAM_WE = 4'h0;
      end
      #1;
      if (iter == lockout_iter) begin
        checkOutput("lockout_rddata", bus1.BRAM_RDDATA, 32'h0);
      end
      if (bus1.dump_valid) begin
        if (stalled) begin
          checkOutput("stall_data", bus1.dump_data, held_data);
          checkOutput("stall_addr", 32'(bus1.dump_addr), held_addr);
        end
        if (bus1.dump_ready) begin
          exp = beat_q.pop_front();
          checkOutput("beat_addr", 32'(bus1.dump_addr), 32'(exp.addr));
          checkOutput("beat_data", bus1.dump_data, exp.data);
          checkOutput("beat_last", 32'(bus1.dump_last), 32'(exp.last));
          beats++;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          held_data = bus1.dump_data;
          held_addr = 32'(bus1.dump_addr);
        end
      end else begin
        checkOutput("last_without_valid", 32'(bus1.dump_last), 32'h0);
      end
      iter++;
      @(posedge aclk);
      #1;
      if (abort_after != 0 && beats == abort_after) break;
    end
    bus1.dump_ready = 1'b0;
  endtask

  initial begin
    int          beats2;
    int          last_accept;
    bit          saw_activity;
    beat_t       exp;

    aresetn = 1'b0;
    bus1.BRAM_ADDR = '0; bus1.BRAM_WRDATA = '0; bus1.BRAM_WE = '0; bus1.BRAM_EN = 1'b0;
    bus1.BRAM_RST = 1'b0; bus1.ld_valid = 1'b0; bus1.ld_addr = '0; bus1.ld_data = '0;
    bus1.done = 1'b0; bus1.dump_ready = 1'b0;
    bus2.BRAM_ADDR = '0; bus2.BRAM_WRDATA = '0; bus2.BRAM_WE = '0; bus2.BRAM_EN = 1'b0;
    bus2.BRAM_RST = 1'b0; bus2.ld_valid = 1'b0; bus2.ld_addr = '0; bus2.ld_data = '0;
    bus2.done = 1'b0; bus2.dump_ready = 1'b0;
    repeat (3) tick();
    checkResetState("reset");
    aresetn = 1'b1;
    tick();

    // Preload and read at latency 1, then hold with EN low, then BRAM_RST clear
    loadWord(5, 32'hDEAD_BEEF);
    applyStimulus(4'h0, 5, 32'h0, "l1_read");
    tick();
    checkOutput("l1_hold_en0", bus1.BRAM_RDDATA, 32'hDEAD_BEEF);
    bus1.BRAM_RST = 1'b1; bus1.BRAM_EN = 1'b1; bus1.BRAM_ADDR = 15'h14;
    tick();
    bus1.BRAM_RST = 1'b0; bus1.BRAM_EN = 1'b0;
    checkOutput("bram_rst_clear", bus1.BRAM_RDDATA, 32'h0);
    tick();
    checkOutput("bram_rst_hold", bus1.BRAM_RDDATA, 32'h0);

    // Preload and read at latency 2
    bus2.ld_valid = 1'b1; bus2.ld_addr = WAW'(5); bus2.ld_data = 32'hDEAD_BEEF;
    tick();
    bus2.ld_valid = 1'b0;
    rd_q.push_back(32'hDEAD_BEEF);
    bus2.BRAM_EN = 1'b1; bus2.BRAM_ADDR = 15'h14;
    tick();
    bus2.BRAM_EN = 1'b0;
    checkOutput("l2_read_after_1", bus2.BRAM_RDDATA, 32'h0);
    tick();
    checkOutput("l2_read_after_2", bus2.BRAM_RDDATA, rd_q.pop_front());

    // Byte-lane write with read-first on the same cycle
    loadWord(3, 32'h1122_3344);
    applyStimulus(4'b0101, 3, 32'hAABB_CCDD, "read_during_write");
    applyStimulus(4'h0, 3, 32'h0, "byte_lane_read");
    checkOutput("byte_lane_const", bus1.BRAM_RDDATA, 32'h11BB_33DD);

    // Load stalled by three port-write cycles
    bus1.ld_valid = 1'b1; bus1.ld_addr = WAW'(8); bus1.ld_data = 32'h8888_8888;
    for (int k = 0; k < 3; k++) begin
      bus1.BRAM_EN = 1'b1; bus1.BRAM_WE = 4'hF;
      bus1.BRAM_ADDR = 15'h1C; bus1.BRAM_WRDATA = 32'h7777_7777;
      #1;
      checkOutput("ld_stall_ready", 32'(bus1.ld_ready), 32'h0);
      tick();
    end
    model_mem[7] = 32'h7777_7777;
    bus1.BRAM_EN = 1'b0; bus1.BRAM_WE = 4'h0;
    #1;
    checkOutput("ld_resume_ready", 32'(bus1.ld_ready), 32'h1);
    tick();
    bus1.ld_valid = 1'b0;
    model_mem[8] = 32'h8888_8888;
    applyStimulus(4'h0, 8, 32'h0, "ld_after_stall");
    applyStimulus(4'h0, 7, 32'h0, "port_word_kept");

    // Dump with alternating back-pressure and a locked-out port write
    for (int i = 0; i < 64; i++) loadWord(i, 32'h100 + i);
    checkOutput("conflict_pre", 32'(bus1.conflict), 32'h0);
    bus1.done = 1'b1;
    tick();
    bus1.done = 1'b0;
    checkOutput("dump_busy_start", 32'(bus1.busy), 32'h1);
    checkOutput("dump_valid_n", 32'(bus1.dump_valid), 32'h0);
    tick();
    checkOutput("dump_valid_n1", 32'(bus1.dump_valid), 32'h0);
    tick();
    checkOutput("dump_valid_n2", 32'(bus1.dump_valid), 32'h1);
    pushDump(0, 64);
    runDump(0, 1'b1, 20);
    checkOutput("busy_after_last", 32'(bus1.busy), 32'h0);
    checkOutput("conflict_sticky", 32'(bus1.conflict), 32'h1);
    applyStimulus(4'h0, 0, 32'h0, "word0_unchanged");
    checkOutput("word0_const", bus1.BRAM_RDDATA, 32'h100);
    checkOutput("conflict_still", 32'(bus1.conflict), 32'h1);

    // Reset at beat 10 with done held high
    bus1.done = 1'b1;
    tick();
    pushDump(0, 64);
    runDump(10, 1'b0, -10);
    aresetn = 1'b0;
    #1;
    checkResetState("mid_reset");
    beat_q.delete();
    repeat (2) tick();
    aresetn = 1'b1;
    saw_activity = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus1.busy || bus1.dump_valid) saw_activity = 1'b1;
    end
    checkOutput("no_dump_after_reset", 32'(saw_activity), 32'h0);

    // Fresh done edge runs a full dump from the base with memory intact
    bus1.done = 1'b0;
    tick();
    bus1.done = 1'b1;
    tick();
    checkOutput("redump_busy", 32'(bus1.busy), 32'h1);
    pushDump(0, 64);
    runDump(0, 1'b0, -10);
    checkOutput("redump_busy_end", 32'(bus1.busy), 32'h0);
    bus1.done = 1'b0;

    // Latency-2 dump: start latency, per-word spacing, window bounds
    for (int i = 2; i < 6; i++) begin
      bus2.ld_valid = 1'b1; bus2.ld_addr = WAW'(i); bus2.ld_data = 32'h200 + i;
      model_mem[i] = 32'h200 + i;
      tick();
    end
    bus2.ld_valid = 1'b0;
    bus2.done = 1'b1;
    tick();
    bus2.done = 1'b0;
    checkOutput("l2_busy_start", 32'(bus2.busy), 32'h1);
    tick();
    checkOutput("l2_valid_n1", 32'(bus2.dump_valid), 32'h0);
    tick();
    checkOutput("l2_valid_n2", 32'(bus2.dump_valid), 32'h0);
    tick();
    checkOutput("l2_valid_n3", 32'(bus2.dump_valid), 32'h1);
    pushDump(2, 4);
    bus2.dump_ready = 1'b1;
    beats2 = 0;
    last_accept = -1;
    for (int c = 0; c < 40 && beats2 < 4; c++) begin
      if (bus2.dump_valid) begin
        exp = beat_q.pop_front();
        checkOutput("l2_beat_addr", 32'(bus2.dump_addr), 32'(exp.addr));
        checkOutput("l2_beat_data", bus2.dump_data, exp.data);
        checkOutput("l2_beat_last", 32'(bus2.dump_last), 32'(exp.last));
        if (last_accept >= 0) checkOutput("l2_beat_gap", 32'(c - last_accept), 32'd4);
        last_accept = c;
        beats2++;
      end
      tick();
    end
    bus2.dump_ready = 1'b0;
    checkOutput("l2_beat_count", 32'(beats2), 32'd4);
    checkOutput("l2_busy_end", 32'(bus2.busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
